// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, synchronous SRAM issue, stall capture and redirect.
// Define FETCH_PERF_CNT_EN to build the fetch/stall performance counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_cs,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_add4_out,
  output logic        inst_valid,
  output logic        flush_out,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] target;
  logic [31:0] addr_sel;
  logic        cs_sel;
  logic [31:0] sel_inst;

  assign target = {redirect_pc[31:2], 2'b00};

  // Data presented to IF/ID: held copy while stalled, otherwise straight from the SRAM.
  always_comb begin
    sel_inst = 32'h0000_0000;
    if (!resp_valid_q) begin
      sel_inst = 32'h0000_0000;
    end else if (state_q == HOLD) begin
      sel_inst = hold_q;
    end else begin
      sel_inst = im_rdata;
    end
  end

  assign inst_out    = rst ? 32'h0000_0000 : sel_inst;
  assign pc_add4_out = (rst || !resp_valid_q) ? 32'h0000_0000 : (resp_pc_q + 32'd4);
  assign inst_valid  = rst ? 1'b0 : resp_valid_q;
  assign im_cs       = rst ? 1'b0 : cs_sel;
  assign im_addr     = {addr_sel[31:2], 2'b00};
  assign flush_out   = rst ? 1'b0 : redirect;

  // Next-state and SRAM issue logic; redirect overrides any stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    hold_d       = hold_q;
    cs_sel       = 1'b0;
    addr_sel     = pc_q;
    if (redirect) begin
      cs_sel       = 1'b1;
      addr_sel     = target;
      pc_d         = target + 32'd4;
      resp_pc_d    = target;
      resp_valid_d = 1'b1;
      state_d      = RUN;
    end else begin
      case (state_q)
        BOOT, HOLD: begin
          if (pc_write) begin
            cs_sel       = 1'b1;
            addr_sel     = pc_q;
            pc_d         = pc_q + 32'd4;
            resp_pc_d    = pc_q;
            resp_valid_d = 1'b1;
            state_d      = RUN;
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          if (pc_write) begin
            cs_sel       = 1'b1;
            addr_sel     = pc_q;
            pc_d         = pc_q + 32'd4;
            resp_pc_d    = pc_q;
            resp_valid_d = 1'b1;
            state_d      = RUN;
          end else begin
            // SRAM is deselected next cycle, so keep the word it is returning now.
            hold_d  = sel_inst;
            state_d = HOLD;
          end
        end
        default: begin
          state_d      = BOOT;
          resp_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
      hold_q       <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      hold_q       <= hold_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Fetch and stall event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      if (cs_sel) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end else begin
        fetch_cnt_q <= fetch_cnt_q;
      end
      if (!pc_write && !redirect) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign perf_fetch_cnt = rst ? 32'h0000_0000 : fetch_cnt_q;
  assign perf_stall_cnt = rst ? 32'h0000_0000 : stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0000_0000;
  assign perf_stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, perf-counter sequence, randomized model check.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_cs;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_add4_out;
  logic        inst_valid;
  logic        flush_out;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int n_total = 0;
  int n_pass  = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_cs(im_cs), .im_addr(im_addr),
    .im_rdata(im_rdata), .inst_out(inst_out), .pc_add4_out(pc_add4_out),
    .inst_valid(inst_valid), .flush_out(flush_out),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  // Synchronous SRAM; its output is junk whenever it was not selected.
  always @(posedge clk) begin
    if (im_cs) im_rdata <= mem_word(im_addr);
    else       im_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic pw, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; pc_write = pw; redirect = rd; redirect_pc = rpc;
    #1;
  endtask

  typedef struct {
    logic        rst, pw, rd;
    logic [31:0] rpc;
    logic        cs;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst, add4;
    logic        flush;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic pw, input logic rd, input logic [31:0] rpc,
                              input logic cs, input logic [31:0] addr, input logic valid,
                              input logic [31:0] inst, input logic [31:0] add4, input logic flush);
    vec_t v;
    v.rst = r; v.pw = pw; v.rd = rd; v.rpc = rpc; v.cs = cs; v.addr = addr;
    v.valid = valid; v.inst = inst; v.add4 = add4; v.flush = flush;
    vq.push_back(v);
  endfunction

  // Reference model state: the instruction currently presented and the next sequential address.
  logic        m_valid;
  logic [31:0] m_pc, m_next;
  logic [31:0] m_fetch, m_stall;

  task automatic model_cycle(input logic r, input logic pw, input logic rd, input logic [31:0] rpc);
    logic [31:0] t;
    logic        e_cs;
    t = {rpc[31:2], 2'b00};
    drive(r, pw, rd, rpc);
    e_cs = !r && (rd || pw);
    chk("rnd_cs", {31'd0, im_cs}, {31'd0, e_cs});
    if (e_cs) chk("rnd_addr", im_addr, rd ? t : m_next);
    chk("rnd_flush", {31'd0, flush_out}, {31'd0, !r && rd});
    chk("rnd_valid", {31'd0, inst_valid}, {31'd0, !r && m_valid});
    chk("rnd_inst", inst_out, (!r && m_valid) ? mem_word(m_pc) : 32'h0000_0000);
    chk("rnd_add4", pc_add4_out, (!r && m_valid) ? m_pc + 32'd4 : 32'h0000_0000);
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_perf_fetch", perf_fetch_cnt, r ? 32'h0000_0000 : m_fetch);
    chk("rnd_perf_stall", perf_stall_cnt, r ? 32'h0000_0000 : m_stall);
`else
    chk("rnd_perf_fetch", perf_fetch_cnt, 32'h0000_0000);
    chk("rnd_perf_stall", perf_stall_cnt, 32'h0000_0000);
`endif
    if (r) begin
      m_valid = 1'b0; m_next = 32'h0000_0000; m_fetch = 32'd0; m_stall = 32'd0;
    end else begin
      if (e_cs) m_fetch = m_fetch + 32'd1;
      if (!pw && !rd) m_stall = m_stall + 32'd1;
      if (rd) begin
        m_pc = t; m_valid = 1'b1; m_next = t + 32'd4;
      end else if (pw) begin
        m_pc = m_next; m_valid = 1'b1; m_next = m_next + 32'd4;
      end
    end
  endtask

  initial begin
    rst = 1'b1; pc_write = 1'b0; redirect = 1'b0; redirect_pc = 32'h0000_0000;
    m_valid = 1'b0; m_pc = 32'h0; m_next = 32'h0; m_fetch = 32'd0; m_stall = 32'd0;

    // rst pw rd rpc | cs addr valid inst add4 flush
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0,   1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0,   1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'h4,   1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h1,         32'h8,   1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h2,         32'hC,   1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'h3,         32'h10,  1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h14,        1'b1, 32'h4,         32'h14,  1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h5,         32'h18,  1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h5,         32'h18,  1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h5,         32'h18,  1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h18,        1'b1, 32'h5,         32'h18,  1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C,        1'b1, 32'h6,         32'h1C,  1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h20,        1'b1, 32'h7,         32'h20,  1'b0);
    add(1'b0, 1'b1, 1'b1, 32'h100,       1'b1, 32'h100,       1'b1, 32'h8,         32'h24,  1'b1);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h104,       1'b1, 32'h40,        32'h104, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h108,       1'b1, 32'h41,        32'h108, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'h200,       1'b1, 32'h200,       1'b1, 32'h42,        32'h10C, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h204,       1'b1, 32'h80,        32'h204, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h81,        32'h208, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'h300,       1'b1, 32'h300,       1'b1, 32'h81,        32'h208, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h304,       1'b1, 32'hC0,        32'h304, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hC1,        32'h308, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h3FFF_FFFF, 32'h0,   1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'h4,   1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1,         32'h8,   1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1,         32'h8,   1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0,   1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0,   1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'h4,   1'b0);

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].pw, vq[i].rd, vq[i].rpc);
      chk($sformatf("vec%0d_cs", i), {31'd0, im_cs}, {31'd0, vq[i].cs});
      if (vq[i].cs) chk($sformatf("vec%0d_addr", i), im_addr, vq[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vq[i].valid});
      chk($sformatf("vec%0d_inst", i), inst_out, vq[i].inst);
      chk($sformatf("vec%0d_add4", i), pc_add4_out, vq[i].add4);
      chk($sformatf("vec%0d_flush", i), {31'd0, flush_out}, {31'd0, vq[i].flush});
    end

    // Counter sequence: reset, 10 fetches, 3 stalls.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("perf_fetch_reset", perf_fetch_cnt, 32'h0);
    chk("perf_stall_reset", perf_stall_cnt, 32'h0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_10", perf_fetch_cnt, 32'd10);
    chk("perf_stall_3", perf_stall_cnt, 32'd3);
`else
    chk("perf_fetch_tied", perf_fetch_cnt, 32'd0);
    chk("perf_stall_tied", perf_stall_cnt, 32'd0);
`endif

    // Randomized traffic against the reference model.
    model_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2000; i++) begin
      logic        r, pw, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 49) == 0);
      pw  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      model_cycle(r, pw, rd, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage driving the IF/ID pipeline register: holds the program counter, issues reads to a synchronous instruction SRAM (1-cycle read latency), and presents the returned instruction with its PC+4. It also honours the hazard unit's stall (`pc_write`) and the EX-stage redirect, and generates the flush that clears IF/ID. On stall it captures the in-flight instruction so the SRAM can be deselected without losing data.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset (word aligned)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pc_write`  in  1  1 = fetch may advance; 0 = stall (same signal that drives IF/ID write enable)
- `redirect`  in  1  taken branch/jump resolved downstream
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (forced 0)
- `im_cs`  out  1  instruction SRAM chip select
- `im_addr`  out  32  SRAM byte address, bits [1:0] always 0
- `im_rdata`  in  32  SRAM read data, valid the cycle after `im_cs`
- `inst_out`  out  32  instruction to IF/ID
- `pc_add4_out`  out  32  PC+4 of `inst_out`
- `inst_valid`  out  1  `inst_out` is a real fetched instruction
- `flush_out`  out  1  clear IF/ID this cycle (= `redirect`)
- `perf_fetch_cnt`, `perf_stall_cnt`  out  32 each  see Configuration

## Operation
- Registers: `pc_q` (next fetch address), `resp_pc_q` (address of data arriving now), `resp_valid_q`, `hold_q[31:0]`, state ∈ {BOOT, RUN, HOLD}.
- Output mux: `inst_out` = 0 if !`resp_valid_q`; `hold_q` in HOLD; else `im_rdata`. `pc_add4_out` = `resp_valid_q` ? `resp_pc_q`+4 : 0. `inst_valid` = `resp_valid_q`.
- Priority per cycle: `rst` > `redirect` > `pc_write`=0 > normal advance.
- Redirect (any state): `im_cs`=1, `im_addr`=`redirect_pc` (combinational bypass), `flush_out`=1; next: `pc_q`←target+4, `resp_pc_q`←target, `resp_valid_q`←1, state RUN. A simultaneous stall is discarded.
- BOOT, `pc_write`=1: `im_cs`=1, `im_addr`=`pc_q`; next `pc_q`+=4, `resp_pc_q`←`pc_q`, `resp_valid_q`←1, →RUN. With `pc_write`=0: `im_cs`=0, stay BOOT.
- RUN, `pc_write`=1: same issue/advance as BOOT, stay RUN.
- RUN, `pc_write`=0: `im_cs`=0; `hold_q`←current `inst_out`; `pc_q`, `resp_pc_q` unchanged; →HOLD.
- HOLD, `pc_write`=0: `im_cs`=0, outputs frozen from `hold_q`.
- HOLD, `pc_write`=1: output still `hold_q` (consumed by IF/ID this edge); `im_cs`=1 at `pc_q`; next `pc_q`+=4, `resp_pc_q`←`pc_q`, →RUN.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No alignment fault is raised.

## Timing
- Reset (cycle `rst`=1 and after): state BOOT, `pc_q`=`RESET_PC`, `resp_valid_q`=0, `hold_q`=0. While `rst`=1: `im_cs`=0, `inst_out`=0, `pc_add4_out`=0, `inst_valid`=0, `flush_out`=0, counters 0. Reset mid-stall or mid-redirect discards all state.
- First valid instruction: 2 cycles after `rst` deasserts (issue in BOOT, data next cycle).
- Steady state: one instruction per cycle. Redirect penalty: exactly one bubble (flushed slot); target instruction appears the cycle after `redirect`.
- Stall: `inst_out`/`pc_add4_out` stable for every cycle `pc_write`=0 and the first cycle it returns to 1; the next sequential instruction follows the cycle after.
- `flush_out`, `im_cs`, `im_addr` are combinational from state and inputs. All other outputs depend on registers plus `im_rdata` only.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `perf_fetch_cnt` increments on each cycle `im_cs`=1; `perf_stall_cnt` increments on each cycle with `pc_write`=0 and `redirect`=0 outside reset. Both wrap at 2^32 and clear on `rst`.
- Not defined: both ports are tied to 0 and no counter flops are built. The port list is unchanged.

## Test plan
- Reset release, `RESET_PC`=0, memory word[n]=n: `im_addr` 0,4,8…; `inst_valid` rises on the 2nd cycle; `inst_out`/`pc_add4_out` = 0/4, 1/8, 2/12.
- 3-cycle stall while `inst_out`=5: `im_cs`=0 for 3 cycles; `inst_out`=5 and `pc_add4_out`=24 for 4 cycles; the next output is 6/28.
- Redirect to 32'h100 while at addr 0x20: that cycle has `flush_out`=1 and `im_addr`=0x100; next `inst_out`=word[0x40], `pc_add4_out`=0x104; then 0x108.
- Redirect and `pc_write`=0 in the same cycle, and redirect during HOLD: the redirect wins; the target instruction appears the next cycle.
- `redirect_pc`=32'hFFFF_FFFF: fetch at 0xFFFF_FFFC; the next `im_addr` is 0x0000_0000 with `pc_add4_out`=0x0.
- `rst` asserted during HOLD: the next cycle gives `inst_valid`=0 and `im_addr`=`RESET_PC`. With `FETCH_PERF_CNT_EN`, counters read 0 after reset, and after 10 fetches and 3 stalls read 10/3.
